// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 MULT/MULTU/DIV/DIVU into hi/lo with a start/busy/done handshake.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] Port_A,
  input  logic [WIDTH-1:0] Port_B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic is_div, bzero, neg_q, neg_r, sa, sb;
  logic [WIDTH-1:0] a_raw, d, acc, q, mag_a, mag_b;
  logic [WIDTH:0] sum, trial;
  logic [2*WIDTH-1:0] prod;
  assign sa = ~op[0] & Port_A[WIDTH-1];
  assign sb = ~op[0] & Port_B[WIDTH-1];
  assign mag_a = sa ? -Port_A : Port_A;
  assign mag_b = sb ? -Port_B : Port_B;
  // multiply: acc:q is the shifting product with the multiplier in q; divide: acc is the partial remainder
  assign sum = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
  assign trial = {acc, q[WIDTH-1]} - {1'b0, d};
  assign prod = neg_q ? -{acc, q} : {acc, q};
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt <= '0;
      is_div <= 1'b0;
      bzero <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      a_raw <= '0;
      d <= '0;
      acc <= '0;
      q <= '0;
      hi <= '0;
      lo <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          cnt <= '0;
          div_zero <= 1'b0;
          is_div <= op[1];
          bzero <= Port_B == '0;
          neg_q <= sa ^ sb;
          neg_r <= sa;
          a_raw <= Port_A;
          acc <= '0;
          d <= op[1] ? mag_b : mag_a;
          q <= op[1] ? mag_a : mag_b;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
          if (is_div) begin
            acc <= trial[WIDTH] ? {acc[WIDTH-2:0], q[WIDTH-1]} : trial[WIDTH-1:0];
            q <= {q[WIDTH-2:0], ~trial[WIDTH]};
          end else begin
            acc <= sum[WIDTH:1];
            q <= {sum[0], q[WIDTH-1:1]};
          end
        end
        FIX: begin
          state <= DONE;
          if (is_div && bzero) begin
            hi <= a_raw;
            lo <= '1;
            div_zero <= 1'b1;
          end else if (is_div) begin
            hi <= neg_r ? -acc : acc;
            lo <= neg_q ? -q : q;
          end else begin
            {hi, lo} <= prod;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed scoreboard bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;
  localparam int W = 32;
  logic CLK = 0, nRST = 0, start = 0;
  logic [1:0] op = '0;
  logic [W-1:0] Port_A = '0, Port_B = '0;
  logic busy, done, div_zero;
  logic [W-1:0] hi, lo;
  typedef struct {logic [W-1:0] hi; logic [W-1:0] lo; logic dz;} exp_t;
  exp_t sbq[$];
  exp_t last;
  int compared = 0, mismatched = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .CLK(CLK), .nRST(nRST), .start(start), .op(op), .Port_A(Port_A), .Port_B(Port_B),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sbv, qq, rr;
    logic [63:0] p, ua, ub;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    e.dz = 1'b0;
    if (o == 2'd0) p = sa * sbv;
    else if (o == 2'd1) p = ua * ub;
    else if (b == '0) begin
      p = {a, 32'hFFFF_FFFF};
      e.dz = 1'b1;
    end else if (o == 2'd2) begin
      qq = sa / sbv;
      rr = sa % sbv;
      p = {rr[31:0], qq[31:0]};
    end else begin
      p = {ua % ub, 32'b0} | (ua / ub);
    end
    e.hi = p[63:32];
    e.lo = p[31:0];
    return e;
  endfunction

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge CLK);
    start = 1;
    op = o;
    Port_A = a;
    Port_B = b;
    sbq.push_back(model(o, a, b));
    @(posedge CLK);
    #1 start = 0;
    Port_A = $urandom;
    Port_B = $urandom;
    op = 2'($urandom_range(0, 3));
  endtask

  task automatic finish_op(input string tag);
    int n;
    n = 0;
    while (n < 100) begin
      @(negedge CLK);
      n++;
      if (done) break;
    end
    chk({tag, ".latency"}, 64'(n), 64'(W + 2));
    if (done && sbq.size() > 0) begin
      last = sbq.pop_front();
      chk({tag, ".hi"}, 64'(hi), 64'(last.hi));
      chk({tag, ".lo"}, 64'(lo), 64'(last.lo));
      chk({tag, ".div_zero"}, 64'(div_zero), 64'(last.dz));
    end
    @(negedge CLK);
    chk({tag, ".busy_after"}, 64'(busy), 64'd0);
    chk({tag, ".done_pulse"}, 64'(done), 64'd0);
    chk({tag, ".dz_held"}, 64'(div_zero), 64'(last.dz));
    chk({tag, ".lo_held"}, 64'(lo), 64'(last.lo));
  endtask

  initial begin
    int pulses;
    #1;
    chk("reset.busy", 64'(busy), 64'd0);
    chk("reset.done", 64'(done), 64'd0);
    chk("reset.hi", 64'(hi), 64'd0);
    chk("reset.lo", 64'(lo), 64'd0);
    chk("reset.dz", 64'(div_zero), 64'd0);
    @(negedge CLK);
    nRST = 1;
    repeat (2) @(negedge CLK);
    chk("idle.busy", 64'(busy), 64'd0);

    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max");
    chk("multu_max.k_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max.k_lo", 64'(lo), 64'h1);
    issue(2'd0, -32'sd5, 32'd10);
    finish_op("mult_neg");
    chk("mult_neg.k_lo", 64'(lo), 64'hFFFF_FFCE);
    issue(2'd0, 32'h8000_0000, 32'h8000_0000);
    finish_op("mult_min");
    chk("mult_min.k_hi", 64'(hi), 64'h4000_0000);
    issue(2'd2, -32'sd7, 32'd2);
    finish_op("div_neg");
    chk("div_neg.k_lo", 64'(lo), 64'hFFFF_FFFD);
    issue(2'd3, 32'd15, 32'd10);
    finish_op("divu");
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_min_m1");
    chk("div_min_m1.k_lo", 64'(lo), 64'h8000_0000);
    issue(2'd3, 32'd5, 32'd0);
    finish_op("divu_zero");
    chk("divu_zero.k_dz", 64'(div_zero), 64'd1);
    issue(2'd2, -32'sd9, 32'd0);
    finish_op("div_zero_signed");
    issue(2'd1, 32'd3, 32'd4);
    finish_op("multu_after_dz");
    chk("multu_after_dz.k_lo", 64'(lo), 64'd12);
    issue(2'd2, 32'd1000, -32'sd33);
    finish_op("div_mixed");

    issue(2'd1, 32'd3, 32'd4);
    repeat (5) @(negedge CLK);
    start = 1;
    op = 2'd3;
    Port_A = 32'd9;
    Port_B = 32'd3;
    @(posedge CLK);
    #1 start = 0;
    Port_A = 32'd77;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (done) begin
        pulses++;
        if (sbq.size() > 0) last = sbq.pop_front();
        chk("ignored_start.lo", 64'(lo), 64'(last.lo));
        chk("ignored_start.k_lo", 64'(lo), 64'd12);
      end
    end
    chk("ignored_start.pulses", 64'(pulses), 64'd1);
    chk("ignored_start.busy", 64'(busy), 64'd0);

    issue(2'd2, -32'sd100, 32'd3);
    repeat (10) @(negedge CLK);
    chk("pre_reset.busy", 64'(busy), 64'd1);
    nRST = 0;
    #1;
    void'(sbq.pop_back());
    chk("async_reset.busy", 64'(busy), 64'd0);
    chk("async_reset.done", 64'(done), 64'd0);
    chk("async_reset.hi", 64'(hi), 64'd0);
    chk("async_reset.lo", 64'(lo), 64'd0);
    chk("async_reset.dz", 64'(div_zero), 64'd0);
    @(negedge CLK);
    nRST = 1;
    issue(2'd3, 32'd100, 32'd7);
    finish_op("divu_after_reset");
    chk("divu_after_reset.k_lo", 64'(lo), 64'd14);
    chk("divu_after_reset.k_hi", 64'(hi), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
